bitmask_arbiter: RTL and testbench
==================================

BITMASK_ARBITER -- requirements
Module: bitmask_arbiter

Interface
REQ-001 Parameter M, default 64, SHALL set the mask datapath width; only 32 and 64 are legal.
REQ-002 Parameter TAG_W, default 6, SHALL set the width of the tag that travels with each request.
REQ-003 clk  in  1  SHALL be the single clock for the block.
REQ-004 rst_n  in  1  SHALL be the asynchronous active-low reset.
REQ-005 flush  in  1  SHALL discard all in-flight and pending work when high.
REQ-006 rq_valid[1:0]  in  2  SHALL carry the request valid per requester: 0 = logical-immediate unit, 1 = bitfield unit.
REQ-007 rq_ready[1:0]  out  2  SHALL be the per-requester accept signal.
REQ-008 rq_immN[1:0], rq_imms[1:0][5:0], rq_immr[1:0][5:0]  in  SHALL carry the per-requester encoding fields.
REQ-009 rq_tag[1:0][TAG_W-1:0]  in  SHALL carry an opaque per-request tag.
REQ-010 rs_valid[1:0]  out  2, rs_ready[1:0]  in  2  SHALL form the per-requester response handshake.
REQ-011 rs_wmask[1:0][M-1:0], rs_tmask[1:0][M-1:0], rs_tag[1:0][TAG_W-1:0], rs_illegal[1:0]  out  SHALL carry the per-requester response payload.

Function
REQ-012 The block SHALL own one shared combinational bitmask decoder, driven from stage-1 register S1, with immediate=1 for requester 0 and immediate=0 for requester 1.
REQ-013 A handshake SHALL complete when rq_valid[i] && rq_ready[i] at a rising edge; at most one request SHALL be accepted per cycle.
REQ-014 Arbitration SHALL be round-robin using a 1-bit pointer ptr: when both requesters are valid, grant the requester != last granted; a single valid requester SHALL be granted regardless of ptr.
REQ-015 ptr SHALL update only on an accepted handshake, to the index of the granted requester.
REQ-016 rq_ready[i] SHALL be high iff grant==i && s1_adv && !flush, where s1_adv = !S1.valid || (S1 result moves to its response register this cycle).
REQ-017 rq_ready SHALL NOT depend combinationally on rq_valid of the same requester, except through the grant logic.
REQ-018 S1 SHALL hold {valid, owner, immN, imms, immr, tag}.
REQ-019 The S1 result SHALL move to response register R[owner] when R[owner] is empty or rs_ready[owner] is high that cycle.
REQ-020 Latency: a request accepted at edge N SHALL present rs_valid at edge N+1 when unblocked; sustained throughput SHALL be 1 per cycle.
REQ-021 rs payload SHALL remain stable while rs_valid && !rs_ready; rs_valid SHALL drop after the handshake unless a new result loads in the same edge.
REQ-022 Illegal detection SHALL set len = index of the highest set bit of {immN, ~imms} (7 bits) and levels = (1<<len)-1.
REQ-023 The result SHALL be marked illegal if no bit is set or len==0, if (1<<len) > M, or if owner==0 and (imms & levels)==levels.
REQ-024 For an illegal request, rs_illegal SHALL be 1 and rs_wmask/rs_tmask SHALL be all zeros, never X; the tag SHALL still return.
REQ-025 For a legal request, rs_wmask/rs_tmask SHALL equal the decoder outputs for the S1 fields.
REQ-026 flush SHALL clear S1.valid and both R valid bits at the next edge, block acceptance that cycle, and leave ptr unchanged.
REQ-027 flush SHALL take priority over all simultaneous accepts and moves.
REQ-028 A full R[i] held by !rs_ready[i] SHALL stall S1 only if S1.owner==i; the other requester's traffic SHALL wait behind it (in-order, no bypass).

Reset
REQ-029 On rst_n low, asynchronously: rq_ready=0, rs_valid=0, S1.valid=0, ptr=1 (so requester 0 wins the first tie), rs_illegal=0, and rs_wmask/rs_tmask/rs_tag=0.
REQ-030 Reset asserted mid-operation SHALL drop all pending work with no response emitted; after release, the first accept SHALL occur no earlier than the first edge with rst_n high.

Verification
REQ-031 Req0 immN=1 imms=0x00 immr=0x00 tag=5, rs_ready=1 -> rs_valid[0] one cycle after accept, wmask=0x0000000000000001, tmask=0x0000000000000001, tag=5, illegal=0.
REQ-032 Req1 immN=0 imms=0x3C immr=0x00 -> wmask=tmask=0x5555555555555555, illegal=0; same fields with imms=0x3D -> legal on req1, but illegal (masks 0) when sent on req0.
REQ-033 Both requesters valid continuously for 6 cycles, rs_ready=1 -> grants 0,1,0,1,0,1; one response per cycle.
REQ-034 rs_ready[0]=0 with R[0] full and S1 owned by requester 0 -> rq_ready=00 and payloads stable; raise rs_ready[0] -> drain resumes with no loss or duplication.
REQ-035 flush asserted in the same cycle as an rq handshake attempt and with S1/R occupied -> no accept, all rs_valid=0 next cycle, ptr unchanged.
REQ-036 M=32 with immN=1 -> illegal=1; rst_n pulsed low mid-stream -> all outputs at reset values immediately, no stale response afterward.

Source files
------------

// File: rtl/bitmask_arbiter_if.sv
// rtl/bitmask_arbiter_if.sv - request/response bundle between two requesters and the bitmask arbiter
//
// Purpose: carries the per-requester request handshake with its encoding fields
// (immn/imms/immr/tag) and the per-requester response handshake with its
// decoded masks.
// Ports (signals): rq_valid/rq_ready, rq_immn, rq_imms, rq_immr, rq_tag,
//                  rs_valid/rs_ready, rs_wmask, rs_tmask, rs_tag, rs_illegal.
// Modports: master = requester side, slave = arbiter side.
interface bitmask_arbiter_if #(
  parameter int M     = 64,
  parameter int TAG_W = 6
);
  logic [1:0]            rq_valid;
  logic [1:0]            rq_ready;
  logic [1:0]            rq_immn;
  logic [1:0][5:0]       rq_imms;
  logic [1:0][5:0]       rq_immr;
  logic [1:0][TAG_W-1:0] rq_tag;

  logic [1:0]            rs_valid;
  logic [1:0]            rs_ready;
  logic [1:0][M-1:0]     rs_wmask;
  logic [1:0][M-1:0]     rs_tmask;
  logic [1:0][TAG_W-1:0] rs_tag;
  logic [1:0]            rs_illegal;

  modport master (
    output rq_valid, rq_immn, rq_imms, rq_immr, rq_tag, rs_ready,
    input  rq_ready, rs_valid, rs_wmask, rs_tmask, rs_tag, rs_illegal
  );

  modport slave (
    input  rq_valid, rq_immn, rq_imms, rq_immr, rq_tag, rs_ready,
    output rq_ready, rs_valid, rs_wmask, rs_tmask, rs_tag, rs_illegal
  );
endinterface

// File: rtl/bitmask_arbiter.sv
// rtl/bitmask_arbiter.sv - two-requester round-robin front end for one shared bitmask decoder
//
// Purpose: accepts at most one request per cycle from requester 0 (logical
// immediate) or requester 1 (bitfield), decodes it from stage register S1 in a
// single shared decoder, and returns wmask/tmask/illegal/tag through a
// per-requester response register R[i]. Results leave S1 strictly in order.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   flush  - drops S1 and both response registers, blocks acceptance
//   bus    - bitmask_arbiter_if slave modport (request and response handshakes)
// Parameter M must be 32 or 64.
module bitmask_arbiter #(
  parameter int M     = 64,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  bitmask_arbiter_if.slave bus
);

  // Stage 1
  logic             s1_valid;
  logic             s1_owner;
  logic             s1_immn;
  logic [5:0]       s1_imms;
  logic [5:0]       s1_immr;
  logic [TAG_W-1:0] s1_tag;

  // Response registers
  logic [1:0]            r_valid;
  logic [1:0][M-1:0]     r_wmask;
  logic [1:0][M-1:0]     r_tmask;
  logic [1:0][TAG_W-1:0] r_tag;
  logic [1:0]            r_illegal;

  // Last granted requester; reset to 1 so requester 0 wins the first tie.
  logic ptr;

  logic       grant;
  logic [1:0] rq_ready_c;
  logic       accept;
  logic       s1_move;
  logic       s1_adv;

  // Decoder
  logic         immediate;
  logic [6:0]   len_src;
  logic [2:0]   dec_len;
  logic         dec_any;
  logic [5:0]   levels;
  logic [5:0]   s_val;
  logic [5:0]   r_val;
  logic [5:0]   d_val;
  logic [5:0]   pos;
  logic [M-1:0] dec_wmask;
  logic [M-1:0] dec_tmask;
  logic         dec_illegal;

  assign immediate = (s1_owner == 1'b0);

  // Element-relative formulation of DecodeBitMasks: bit j sits at position
  // pos = j mod esize inside its element. The rotated welem bit is set when
  // (pos + R) mod esize <= S, and telem is set when pos <= d. Replication
  // across the M-bit word falls out of using pos instead of j.
  always_comb begin
    len_src   = {s1_immn, ~s1_imms};
    dec_len   = 3'd0;
    dec_any   = 1'b0;
    for (int b = 0; b < 7; b++) begin
      if (len_src[b]) begin
        dec_len = 3'(b);
        dec_any = 1'b1;
      end
    end
    levels    = 6'((7'd1 << dec_len) - 7'd1);
    s_val     = s1_imms & levels;
    r_val     = s1_immr & levels;
    d_val     = (s_val - r_val) & levels;
    pos       = 6'd0;
    dec_wmask = '0;
    dec_tmask = '0;
    for (int j = 0; j < M; j++) begin
      pos          = 6'(j) & levels;
      dec_wmask[j] = (((pos + r_val) & levels) <= s_val);
      dec_tmask[j] = (pos <= d_val);
    end
    dec_illegal = !dec_any || (dec_len == 3'd0) ||
                  ((32'd1 << dec_len) > 32'(M)) ||
                  (immediate && (s_val == levels));
  end

  // S1 drains into R[owner] when that register is empty or being consumed.
  assign s1_move = s1_valid && (!r_valid[s1_owner] || bus.rs_ready[s1_owner]);
  assign s1_adv  = !s1_valid || s1_move;

  always_comb begin
    case (bus.rq_valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~ptr;
    endcase
  end

  // rst_n gates ready so nothing can look accepted while reset is held.
  always_comb begin
    rq_ready_c = 2'b00;
    if (rst_n && !flush && s1_adv) begin
      rq_ready_c[grant] = 1'b1;
    end
  end

  assign accept       = |(bus.rq_valid & rq_ready_c);
  assign bus.rq_ready = rq_ready_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b1;
      s1_valid  <= 1'b0;
      s1_owner  <= 1'b0;
      s1_immn   <= 1'b0;
      s1_imms   <= '0;
      s1_immr   <= '0;
      s1_tag    <= '0;
      r_valid   <= '0;
      r_wmask   <= '0;
      r_tmask   <= '0;
      r_tag     <= '0;
      r_illegal <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      r_valid  <= '0;
    end else begin
      if (accept) begin
        ptr      <= grant;
        s1_valid <= 1'b1;
        s1_owner <= grant;
        s1_immn  <= bus.rq_immn[grant];
        s1_imms  <= bus.rq_imms[grant];
        s1_immr  <= bus.rq_immr[grant];
        s1_tag   <= bus.rq_tag[grant];
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (s1_move && (s1_owner == 1'(i))) begin
          r_valid[i]   <= 1'b1;
          r_wmask[i]   <= dec_illegal ? '0 : dec_wmask;
          r_tmask[i]   <= dec_illegal ? '0 : dec_tmask;
          r_tag[i]     <= s1_tag;
          r_illegal[i] <= dec_illegal;
        end else if (bus.rs_ready[i]) begin
          r_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rs_valid   = r_valid;
  assign bus.rs_wmask   = r_wmask;
  assign bus.rs_tmask   = r_tmask;
  assign bus.rs_tag     = r_tag;
  assign bus.rs_illegal = r_illegal;

endmodule

// File: tb/tb_bitmask_arbiter.sv
// tb/tb_bitmask_arbiter.sv - self-checking bench for bitmask_arbiter
module tb_bitmask_arbiter;

  logic clk;
  logic rst_n;
  logic flush;
  logic flush32;

  bitmask_arbiter_if #(.M(64), .TAG_W(6)) bus ();
  bitmask_arbiter_if #(.M(32), .TAG_W(6)) bus32 ();

  bitmask_arbiter #(.M(64), .TAG_W(6)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  bitmask_arbiter #(.M(32), .TAG_W(6)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush32),
    .bus  (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        owner;
    logic        immn;
    logic [5:0]  imms;
    logic [5:0]  immr;
    logic [5:0]  tag;
    logic [63:0] wmask;
    logic [63:0] tmask;
    logic        illegal;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 6'h00, 6'h00, 6'd5,  64'h0000000000000001, 64'h0000000000000001, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 6'h3C, 6'h00, 6'd6,  64'h5555555555555555, 64'h5555555555555555, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 6'h3D, 6'h00, 6'd7,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 6'h3D, 6'h00, 6'd8,  64'h0,                64'h0,                1'b1};
    vecs[4]  = '{1'b0, 1'b1, 6'h07, 6'h00, 6'd9,  64'h00000000000000FF, 64'h00000000000000FF, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 6'h00, 6'h01, 6'd10, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 6'h3F, 6'h00, 6'd11, 64'h0,                64'h0,                1'b1};
    vecs[7]  = '{1'b1, 1'b0, 6'h1F, 6'h00, 6'd12, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 6'h1F, 6'h00, 6'd13, 64'h0,                64'h0,                1'b1};
    vecs[9]  = '{1'b0, 1'b0, 6'h30, 6'h02, 6'd14, 64'h4040404040404040, 64'h7F7F7F7F7F7F7F7F, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 6'h20, 6'h13, 6'd15, 64'h2000200020002000, 64'h3FFF3FFF3FFF3FFF, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 6'h3B, 6'h01, 6'd16, 64'h0,                64'h0,                1'b1};
    vecs[12] = '{1'b1, 1'b0, 6'h3B, 6'h01, 6'd17, 64'hFFFFFFFFFFFFFFFF, 64'h7777777777777777, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    flush32 = 1'b0;
    bus.rq_valid = 2'b00; bus.rq_immn = '0; bus.rq_imms = '0; bus.rq_immr = '0;
    bus.rq_tag = '0; bus.rs_ready = 2'b11;
    bus32.rq_valid = 2'b00; bus32.rq_immn = '0; bus32.rq_imms = '0; bus32.rq_immr = '0;
    bus32.rq_tag = '0; bus32.rs_ready = 2'b11;

    // Reset state, with requests offered to show ready is held low.
    repeat (2) @(negedge clk);
    bus.rq_valid = 2'b11;
    #1;
    chk("reset_rq_ready", 64'(bus.rq_ready), 64'h0);
    chk("reset_rs_valid", 64'(bus.rs_valid), 64'h0);
    chk("reset_rs_illegal", 64'(bus.rs_illegal), 64'h0);
    chk("reset_rs_wmask0", bus.rs_wmask[0], 64'h0);
    chk("reset_rs_tmask1", bus.rs_tmask[1], 64'h0);
    chk("reset_rs_tag", 64'(bus.rs_tag), 64'h0);
    bus.rq_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin: both valid for 6 cycles, first tie goes to requester 0.
    @(negedge clk);
    bus.rq_immn[0] = 1'b1; bus.rq_imms[0] = 6'h00; bus.rq_immr[0] = 6'h00; bus.rq_tag[0] = 6'd10;
    bus.rq_immn[1] = 1'b0; bus.rq_imms[1] = 6'h3C; bus.rq_immr[1] = 6'h00; bus.rq_tag[1] = 6'd20;
    bus.rq_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k < 6) chk($sformatf("rr_ready_%0d", k), 64'(bus.rq_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k >= 2) begin
        chk($sformatf("rr_rs_valid_%0d", k), 64'(bus.rs_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
        chk($sformatf("rr_rs_tag_%0d", k), 64'(bus.rs_tag[(k % 2 == 0) ? 0 : 1]),
            (k % 2 == 0) ? 64'd10 : 64'd20);
      end else begin
        chk($sformatf("rr_rs_valid_%0d", k), 64'(bus.rs_valid), 64'h0);
      end
      @(negedge clk);
      if (k == 5) bus.rq_valid = 2'b00;
    end
    #1;
    chk("rr_drained", 64'(bus.rs_valid), 64'h0);

    // Single-request decode table.
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      bus.rq_valid = 2'b00;
      bus.rq_valid[vecs[v].owner] = 1'b1;
      bus.rq_immn[vecs[v].owner]  = vecs[v].immn;
      bus.rq_imms[vecs[v].owner]  = vecs[v].imms;
      bus.rq_immr[vecs[v].owner]  = vecs[v].immr;
      bus.rq_tag[vecs[v].owner]   = vecs[v].tag;
      #1;
      chk($sformatf("v%0d_rq_ready", v), 64'(bus.rq_ready), vecs[v].owner ? 64'h2 : 64'h1);
      @(negedge clk);
      bus.rq_valid = 2'b00;
      chk($sformatf("v%0d_latency", v), 64'(bus.rs_valid), 64'h0);
      @(negedge clk);
      chk($sformatf("v%0d_rs_valid", v), 64'(bus.rs_valid), vecs[v].owner ? 64'h2 : 64'h1);
      chk($sformatf("v%0d_wmask", v), bus.rs_wmask[vecs[v].owner], vecs[v].wmask);
      chk($sformatf("v%0d_tmask", v), bus.rs_tmask[vecs[v].owner], vecs[v].tmask);
      chk($sformatf("v%0d_tag", v), 64'(bus.rs_tag[vecs[v].owner]), 64'(vecs[v].tag));
      chk($sformatf("v%0d_illegal", v), 64'(bus.rs_illegal[vecs[v].owner]), 64'(vecs[v].illegal));
    end

    // Stall: R0 held full, S1 owned by requester 0, requester 1 waits behind.
    @(negedge clk);
    bus.rs_ready = 2'b10;
    bus.rq_immn[0] = 1'b1; bus.rq_imms[0] = 6'h00; bus.rq_immr[0] = 6'h00; bus.rq_tag[0] = 6'd1;
    bus.rq_valid = 2'b01;
    @(negedge clk);
    bus.rq_imms[0] = 6'h07; bus.rq_tag[0] = 6'd2;
    @(negedge clk);
    bus.rq_valid = 2'b10;
    bus.rq_immn[1] = 1'b0; bus.rq_imms[1] = 6'h3C; bus.rq_immr[1] = 6'h00; bus.rq_tag[1] = 6'd3;
    chk("stall_first_resp", 64'(bus.rs_valid), 64'h1);
    chk("stall_first_tag", 64'(bus.rs_tag[0]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall_rq_ready_%0d", k), 64'(bus.rq_ready), 64'h0);
      chk($sformatf("stall_rs_valid_%0d", k), 64'(bus.rs_valid), 64'h1);
      chk($sformatf("stall_tag_%0d", k), 64'(bus.rs_tag[0]), 64'd1);
      chk($sformatf("stall_wmask_%0d", k), bus.rs_wmask[0], 64'h1);
    end
    bus.rs_ready = 2'b11;
    #1;
    chk("stall_release_ready", 64'(bus.rq_ready), 64'h2);
    @(negedge clk);
    bus.rq_valid = 2'b00;
    chk("drain_b_valid", 64'(bus.rs_valid), 64'h1);
    chk("drain_b_tag", 64'(bus.rs_tag[0]), 64'd2);
    chk("drain_b_wmask", bus.rs_wmask[0], 64'hFF);
    @(negedge clk);
    chk("drain_d_valid", 64'(bus.rs_valid), 64'h2);
    chk("drain_d_tag", 64'(bus.rs_tag[1]), 64'd3);
    @(negedge clk);
    chk("drain_done", 64'(bus.rs_valid), 64'h0);

    // Flush with S1 and R0 occupied and a request attempt in the same cycle.
    bus.rs_ready = 2'b00;
    bus.rq_tag[0] = 6'd30; bus.rq_tag[1] = 6'd31;
    bus.rq_valid = 2'b01;
    @(negedge clk);
    bus.rq_valid = 2'b10;
    @(negedge clk);
    chk("flush_pre_r0", 64'(bus.rs_valid), 64'h1);
    bus.rq_valid = 2'b11;
    flush = 1'b1;
    #1;
    chk("flush_rq_ready", 64'(bus.rq_ready), 64'h0);
    @(negedge clk);
    flush = 1'b0;
    bus.rq_valid = 2'b00;
    chk("flush_rs_valid", 64'(bus.rs_valid), 64'h0);
    @(negedge clk);
    chk("flush_no_s1", 64'(bus.rs_valid), 64'h0);
    bus.rs_ready = 2'b11;
    bus.rq_valid = 2'b11;
    #1;
    chk("flush_ptr_kept", 64'(bus.rq_ready), 64'h1);
    @(negedge clk);
    bus.rq_valid = 2'b00;
    repeat (3) @(negedge clk);

    // M=32 instance.
    bus32.rq_immn[0] = 1'b1; bus32.rq_imms[0] = 6'h00; bus32.rq_immr[0] = 6'h00; bus32.rq_tag[0] = 6'd21;
    bus32.rq_valid = 2'b01;
    @(negedge clk);
    bus32.rq_valid = 2'b00;
    @(negedge clk);
    chk("m32_n1_valid", 64'(bus32.rs_valid), 64'h1);
    chk("m32_n1_illegal", 64'(bus32.rs_illegal[0]), 64'h1);
    chk("m32_n1_wmask", 64'(bus32.rs_wmask[0]), 64'h0);
    chk("m32_n1_tag", 64'(bus32.rs_tag[0]), 64'd21);
    bus32.rq_immn[1] = 1'b0; bus32.rq_imms[1] = 6'h3C; bus32.rq_immr[1] = 6'h00; bus32.rq_tag[1] = 6'd22;
    bus32.rq_valid = 2'b10;
    @(negedge clk);
    bus32.rq_valid = 2'b00;
    @(negedge clk);
    chk("m32_legal_illegal", 64'(bus32.rs_illegal[1]), 64'h0);
    chk("m32_legal_wmask", 64'(bus32.rs_wmask[1]), 64'h55555555);
    chk("m32_legal_tmask", 64'(bus32.rs_tmask[1]), 64'h55555555);

    // Reset pulsed mid-stream with work in S1 and R0.
    @(negedge clk);
    bus.rs_ready = 2'b00;
    bus.rq_valid = 2'b01;
    @(negedge clk);
    bus.rq_valid = 2'b10;
    @(negedge clk);
    bus.rq_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("midrst_rs_valid", 64'(bus.rs_valid), 64'h0);
    chk("midrst_rq_ready", 64'(bus.rq_ready), 64'h0);
    chk("midrst_wmask0", bus.rs_wmask[0], 64'h0);
    chk("midrst_tag", 64'(bus.rs_tag), 64'h0);
    chk("midrst_illegal32", 64'(bus32.rs_illegal), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.rq_valid = 2'b00;
    bus.rs_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_no_stale_%0d", k), 64'(bus.rs_valid), 64'h0);
    end
    bus.rq_valid = 2'b11;
    #1;
    chk("midrst_ptr_reset", 64'(bus.rq_ready), 64'h1);
    @(negedge clk);
    bus.rq_valid = 2'b00;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
